// File: rtl/decode_scan_pkg.sv
// Shared definitions for the decoder scan controller.
//   state_t : controller FSM states
//   NLINES  : number of decoder output lines
//   SELW    : width of the decoder select
package decode_scan_pkg;

    localparam int NLINES = 8;
    localparam int SELW   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_ON    = 2'd2,
        S_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/decode_next_line.sv
// Combinational priority search for the next line to scan.
//   mask : set of enabled lines
//   cur  : line currently selected
//   nxt  : lowest set bit above cur, or lowest set bit overall when none is above
//   wrap : 1 when no set bit exists above cur (frame boundary)
// With cur = NLINES-1 the search always wraps, so nxt is the first line of a frame.
module decode_next_line
    import decode_scan_pkg::*;
(
    input  logic [NLINES-1:0] mask,
    input  logic [SELW-1:0]   cur,
    output logic [SELW-1:0]   nxt,
    output logic              wrap
);

    always_comb begin
        nxt  = '0;
        wrap = 1'b1;
        // Descending scans so the last hit is the lowest index.
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (mask[i]) nxt = SELW'(i);
        end
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt  = SELW'(i);
                wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/decode_scan_ctrl.sv
// Scan sequencer feeding a 3-to-8 decoder: each enabled line is selected
// (SETUP), enabled for a dwell time (ON), then blanked (GAP), in ascending
// order. Single-shot or continuous frames.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, stop         : begin scan (ignored while busy) / abort (wins over start)
//   mode_cont           : 1 = continuous frames
//   line_mask           : lines to scan
//   dwell_cfg           : ON cycles per line, 0 behaves as 1
//   dec_sel, dec_en     : decoder data_in / enable
//   busy, done          : not idle / 1-cycle end-of-frame pulse
//   frame_cnt           : completed frames, wrapping
module decode_scan_ctrl
    import decode_scan_pkg::*;
#(
    parameter int DW  = 8,
    parameter int GAP = 1,
    parameter int FCW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_cont,
    input  logic [NLINES-1:0] line_mask,
    input  logic [DW-1:0]     dwell_cfg,
    output logic [SELW-1:0]   dec_sel,
    output logic              dec_en,
    output logic              busy,
    output logic              done,
    output logic [FCW-1:0]    frame_cnt
);

    // One down-counter serves both ON and GAP, so it must hold either load.
    localparam int CW = (DW > $clog2(GAP + 1)) ? DW : $clog2(GAP + 1);
    localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NLINES-1:0]   mask_q, mask_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic                cont_q, cont_d;
    logic [SELW-1:0]     dec_sel_q, dec_sel_d;
    logic                dec_en_q, dec_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [FCW-1:0]      frame_cnt_q, frame_cnt_d;

    logic [NLINES-1:0]   srch_mask;
    logic [SELW-1:0]     srch_cur, srch_nxt;
    logic                srch_wrap;
    logic                step;

    // In IDLE the search looks at the live mask from the top, giving the
    // first line; otherwise it advances through the latched mask.
    assign srch_mask = (state_q == S_IDLE) ? line_mask : mask_q;
    assign srch_cur  = (state_q == S_IDLE) ? SELW'(NLINES - 1) : dec_sel_q;

    decode_next_line u_next (
        .mask (srch_mask),
        .cur  (srch_cur),
        .nxt  (srch_nxt),
        .wrap (srch_wrap)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        dwell_d     = dwell_q;
        cont_d      = cont_q;
        dec_sel_d   = dec_sel_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        step        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop && (line_mask != '0)) begin
                    state_d   = S_SETUP;
                    dec_sel_d = srch_nxt;
                    mask_d    = line_mask;
                    dwell_d   = (dwell_cfg == '0) ? DW'(1) : dwell_cfg;
                    cont_d    = mode_cont;
                end
            end
            S_SETUP: begin
                state_d = S_ON;
                cnt_d   = CW'(dwell_q) - CW'(1);
            end
            S_ON: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    step = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             step  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // On wrap srch_nxt is already the lowest set bit, i.e. the next
        // frame's first line.
        if (step) begin
            state_d = S_SETUP;
            if (srch_wrap) begin
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + FCW'(1);
                if (!cont_q) state_d = S_IDLE;
            end
            if (state_d == S_SETUP) dec_sel_d = srch_nxt;
        end

        // Abort: drop to IDLE, no frame credit, select held.
        if (stop) begin
            state_d     = S_IDLE;
            done_d      = 1'b0;
            frame_cnt_d = frame_cnt_q;
            dec_sel_d   = dec_sel_q;
        end

        dec_en_d = (state_d == S_ON);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
            dec_sel_q   <= '0;
            dec_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            cont_q      <= cont_d;
            dec_sel_q   <= dec_sel_d;
            dec_en_q    <= dec_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign dec_sel   = dec_sel_q;
    assign dec_en    = dec_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_decode_scan_ctrl.sv
// Directed bench for decode_scan_ctrl (DW=8, GAP=1, FCW=8).
module tb_decode_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, mode_cont;
    logic [7:0] line_mask;
    logic [7:0] dwell_cfg;
    logic [2:0] dec_sel;
    logic       dec_en, busy, done;
    logic [7:0] frame_cnt;
    logic [7:0] dec_out;

    int tests = 0;
    int fails = 0;

    decode_scan_ctrl #(.DW(8), .GAP(1), .FCW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .line_mask (line_mask),
        .dwell_cfg (dwell_cfg),
        .dec_sel   (dec_sel),
        .dec_en    (dec_en),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    // Stand-in for the neighbouring 3-to-8 decoder.
    assign dec_out = dec_en ? (8'h01 << dec_sel) : 8'h00;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called while sitting in the frame's first SETUP cycle; returns in the
    // cycle after the last GAP (where done should be visible).
    task automatic scan_frame(input logic [7:0] m, input int dw, input string tag);
        bit first = 1'b1;
        logic [7:0] onehot;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (!first) tick();
                first  = 1'b0;
                onehot = 8'h01 << i;
                chk($sformatf("%s setup en l%0d", tag, i), 32'(dec_en), 0);
                chk($sformatf("%s setup sel l%0d", tag, i), 32'(dec_sel), i);
                chk($sformatf("%s setup busy l%0d", tag, i), 32'(busy), 1);
                for (int d = 0; d < dw; d++) begin
                    tick();
                    chk($sformatf("%s on en l%0d c%0d", tag, i, d), 32'(dec_en), 1);
                    chk($sformatf("%s on dec l%0d c%0d", tag, i, d), 32'(dec_out), 32'(onehot));
                    chk($sformatf("%s on done l%0d c%0d", tag, i, d), 32'(done), 0);
                end
                tick();
                chk($sformatf("%s gap en l%0d", tag, i), 32'(dec_en), 0);
                chk($sformatf("%s gap sel l%0d", tag, i), 32'(dec_sel), i);
                chk($sformatf("%s gap done l%0d", tag, i), 32'(done), 0);
            end
        end
        tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " sel"}, 32'(dec_sel), 0);
        chk({tag, " en"}, 32'(dec_en), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " fcnt"}, 32'(frame_cnt), 0);
    endtask

    task automatic do_start(input logic [7:0] m, input logic [7:0] dw, input logic cont);
        line_mask = m;
        dwell_cfg = dw;
        mode_cont = cont;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
        line_mask = 8'h00; dwell_cfg = 8'd0;
        tick(); tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();
        chk("idle busy", 32'(busy), 0);

        // 1: full mask, dwell 2, single shot -> done 32 cycles after SETUP.
        do_start(8'hFF, 8'd2, 1'b0);
        chk("t1 busy at setup", 32'(busy), 1);
        scan_frame(8'hFF, 2, "t1");
        chk("t1 done", 32'(done), 1);
        chk("t1 busy end", 32'(busy), 0);
        chk("t1 fcnt", 32'(frame_cnt), 1);
        tick();
        chk("t1 done once", 32'(done), 0);
        chk("t1 stays idle", 32'(busy), 0);

        // 2: sparse mask, dwell 3.
        do_start(8'b1000_0010, 8'd3, 1'b0);
        scan_frame(8'b1000_0010, 3, "t2");
        chk("t2 done", 32'(done), 1);
        chk("t2 fcnt", 32'(frame_cnt), 2);
        tick();

        // 3: continuous, single line; later input changes must be ignored.
        do_start(8'h01, 8'd1, 1'b1);
        line_mask = 8'hFF; dwell_cfg = 8'd5; mode_cont = 1'b0;
        for (int f = 0; f < 4; f++) begin
            scan_frame(8'h01, 1, $sformatf("t3f%0d", f));
            chk($sformatf("t3 done f%0d", f), 32'(done), 1);
            chk($sformatf("t3 busy f%0d", f), 32'(busy), 1);
            chk($sformatf("t3 fcnt f%0d", f), 32'(frame_cnt), 3 + f);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3 stop busy", 32'(busy), 0);
        chk("t3 stop done", 32'(done), 0);
        chk("t3 stop fcnt", 32'(frame_cnt), 6);

        // 4: stop during ON of line 3, then start+stop together.
        do_start(8'h08, 8'd4, 1'b0);
        chk("t4 sel", 32'(dec_sel), 3);
        tick(); tick();
        chk("t4 on", 32'(dec_en), 1);
        stop = 1'b1;
        tick();
        chk("t4 en", 32'(dec_en), 0);
        chk("t4 busy", 32'(busy), 0);
        chk("t4 done", 32'(done), 0);
        chk("t4 fcnt", 32'(frame_cnt), 6);
        chk("t4 sel hold", 32'(dec_sel), 3);
        line_mask = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("t4 start+stop busy", 32'(busy), 0);
        tick();
        chk("t4 still idle", 32'(busy), 0);

        // 5: empty mask ignored; dwell 0 behaves as 1.
        do_start(8'h00, 8'd3, 1'b0);
        chk("t5 empty busy", 32'(busy), 0);
        chk("t5 empty done", 32'(done), 0);
        tick();
        chk("t5 empty busy2", 32'(busy), 0);
        do_start(8'h05, 8'd0, 1'b0);
        scan_frame(8'h05, 1, "t5");
        chk("t5 done", 32'(done), 1);
        chk("t5 fcnt", 32'(frame_cnt), 7);
        tick();

        // 6: reset mid-scan, then rescan from lowest set bit.
        do_start(8'hF0, 8'd3, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        chk("t6 mid busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        chk_reset("t6 reset");
        rst_n = 1'b1;
        do_start(8'h0C, 8'd1, 1'b0);
        scan_frame(8'h0C, 1, "t6");
        chk("t6 done", 32'(done), 1);
        chk("t6 fcnt", 32'(frame_cnt), 1);
        chk("t6 busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
